sram_port_sequencer: RTL
========================

# sram_port_sequencer

Request sequencer placed directly upstream of the 512×256-bit byte-masked single-port data array macro. It zero-fills the array after reset, then turns a valid/ready request stream (reads and byte-masked writes) into macro RW0 cycles. It captures the macro's one-cycle read data into a 2-entry response buffer with valid/ready back-pressure. Sits between the cache data-path controller and the data array.

## Interface
- ADDR_W, 9, macro address width (512 rows)
- DATA_W, 256, row width in bits
- MASK_W, 32, byte-lane write-mask width (DATA_W/8)
- RESP_DEPTH, 2, response buffer entries
- INIT_EN, 1, 1 = zero-fill array after reset; 0 = start in RUN

Ports:
- clock  in  1  single clock; also drives macro RW0_clk
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid & ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  row address
- req_wmask  in  MASK_W  byte-lane enables (writes only)
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer takes resp_rdata
- resp_rdata  out  DATA_W  read data, in request order
- sram_en, sram_wmode  out  1 each  macro RW0_en / RW0_wmode
- sram_addr  out  ADDR_W  macro RW0_addr
- sram_wmask  out  MASK_W  macro RW0_wmask
- sram_wdata  out  DATA_W  macro RW0_wdata
- sram_rdata  in  DATA_W  macro RW0_rdata
- init_done  out  1  high once zero-fill is complete

## Operation
- FSM has two states: INIT and RUN.
  - Reset enters INIT if INIT_EN=1, else RUN.
  - INIT → RUN on the cycle after the write to row 2^ADDR_W−1.
- INIT:
  - Each cycle drives sram_en=1, sram_wmode=1, sram_wmask=all-ones, sram_wdata=0, sram_addr=init_ctr.
  - init_ctr starts at 0 and increments by 1 per cycle. It is ADDR_W+1 bits wide, so it does not wrap.
  - req_ready=0 throughout INIT.
- RUN, macro drive:
  - The macro port is driven combinationally from the request: sram_en = req_valid & req_ready, sram_wmode = req_write, and addr/wmask/wdata pass through.
  - When not enabled, sram_wmode=0 and sram_wmask=0.
- RUN, writes: always ready. They generate no response.
- RUN, reads:
  - A read is ready when count + inflight − pop < RESP_DEPTH, where pop = resp_valid & resp_ready.
  - inflight is a 1-bit flag: a read was issued last cycle.
  - When inflight=1, sram_rdata is pushed into the buffer at the clock edge.
- Write-after-read to the same row in the next cycle: the capture edge coincides with the write edge. The old data is returned, because capture samples before the update.
- Response buffer:
  - It is a FIFO with a pointer per side and a count of width clog2(RESP_DEPTH+1).
  - Push and pop in the same cycle leave count unchanged.
  - The credit rule guarantees a push never occurs while the buffer is full. The bench asserts this.
- Reset mid-operation: the FSM, counters, inflight flag and buffer all clear immediately. Any outstanding read is dropped and INIT restarts.

## Timing
- Reset values: req_ready=0 (1 if INIT_EN=0), resp_valid=0, init_done=0 (1 if INIT_EN=0), resp_rdata=0.
  - sram_en=1 and sram_wmode=1 while in INIT; sram_en=0 if INIT_EN=0.
- Zero-fill takes exactly 2^ADDR_W cycles after reset release. init_done and req_ready rise in cycle 2^ADDR_W.
- Read latency:
  - Read accepted in cycle N.
  - Macro data valid in cycle N+1 and captured at the end of N+1.
  - resp_valid=1 in cycle N+2.
- Throughput: one read per cycle sustained while resp_ready=1.
- Back-pressure:
  - With resp_ready=0, at most RESP_DEPTH reads are accepted.
  - req_ready for reads falls once count+inflight=RESP_DEPTH.
  - Writes remain accepted while reads are stalled.
- resp_valid and resp_rdata stay stable while resp_valid & !resp_ready.

## Structure
- Shared package holds:
  - the geometry constants (ADDR_W=9, DATA_W=256, MASK_W=32);
  - the FSM state enum {INIT, RUN};
  - a request struct (write, addr, wmask, wdata).
- The response buffer is one sub-module, sram_resp_fifo, parameterised by DATA_W and RESP_DEPTH, with push/pop/count/full/empty.
- The FSM, init counter, credit logic and macro drive stay in the top module.

## Test plan
- Reset, then idle:
  - Rows 0..511 are written with zero and full mask.
  - init_done and req_ready rise at cycle 512.
  - Reading row 0x1FF returns 0.
- Masked write and readback:
  - Write addr 0x005, wdata=all 0xA5, wmask=0x0000000F.
  - Read back 0x005.
  - resp_rdata has bytes 0–3 = 0xA5 and all other bytes 0, with resp_valid exactly 2 cycles after acceptance.
- Streaming reads:
  - Issue 16 back-to-back reads, rows 0..15, previously written with row index in byte 0, with resp_ready=1.
  - 16 responses arrive on consecutive cycles, in order, with req_ready never dropping.
- Back-pressure:
  - Hold resp_ready=0 and offer 4 reads.
  - Only 2 are accepted; writes are still accepted meanwhile.
  - After resp_ready=1, both responses are delivered in order and the remaining reads proceed.
- Write-after-read hazard:
  - Row 7 holds 0x11…11.
  - Read row 7 in cycle N, then write 0x22…22 (full mask) in cycle N+1.
  - The response is 0x11…11; a following read returns 0x22…22.
- Reset mid-operation:
  - Assert reset_n=0 with 1 read in flight and 1 buffered.
  - resp_valid drops immediately, INIT restarts from row 0, and the former data reads back as 0 afterwards.

Source files
------------

// File: rtl/sram_port_sequencer_pkg.sv
// Shared definitions for the SRAM port sequencer slice.
// Holds the data array geometry, the sequencer state encoding and the
// request record that the top module assembles from the request bus.
package sram_port_sequencer_pkg;

    // Geometry of the 512 x 256-bit byte-masked data array macro.
    localparam int ADDR_W = 9;
    localparam int DATA_W = 256;
    localparam int MASK_W = DATA_W / 8;

    // INIT zero-fills the array; RUN services requests.
    typedef enum logic {
        INIT,
        RUN
    } seq_state_t;

    // One request as it arrives on the request bus.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_port_sequencer_if.sv
// Request/response bus between the cache data-path controller and the
// SRAM port sequencer.
//   master : the controller (drives requests, consumes responses)
//   slave  : the sequencer (accepts requests, produces responses)
// Signals:
//   req_valid/req_ready   request handshake
//   req_write             1 = write, 0 = read
//   req_addr/wmask/wdata  row address, byte-lane enables, write data
//   resp_valid/resp_ready response handshake
//   resp_rdata            read data, returned in request order
interface sram_port_sequencer_if;
    import sram_port_sequencer_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [MASK_W-1:0] req_wmask;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/sram_port_sequencer_resp_fifo.sv
// Response buffer for read data coming back from the data array.
// Small FIFO with a pointer per side and an occupancy count.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   push, push_data  write side (caller never pushes while full)
//   pop, pop_data    read side; pop_data is zero while empty
//   count            current occupancy
//   full, empty      occupancy flags
module sram_resp_fifo #(
    parameter int DATA_W     = 256,
    parameter int RESP_DEPTH = 2,
    localparam int CNT_W     = $clog2(RESP_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic [DATA_W-1:0] mem [RESP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(RESP_DEPTH));
    assign do_pop   = pop & ~empty;
    // Gating with empty gives a clean zero after reset without clearing storage.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_sequencer.sv
// Request sequencer in front of the 512 x 256-bit byte-masked single-port
// data array. After reset it zero-fills every row, then turns the request
// stream into RW0 cycles and buffers the one-cycle-late read data.
// Ports:
//   clock, reset_n     clock (also the macro RW0_clk) and async active-low reset
//   bus                request/response bus (slave side)
//   sram_en/wmode      macro RW0_en / RW0_wmode
//   sram_addr/wmask    macro RW0_addr / RW0_wmask
//   sram_wdata         macro RW0_wdata
//   sram_rdata         macro RW0_rdata, valid the cycle after a read
//   init_done          high once the zero-fill has finished
module sram_port_sequencer
    import sram_port_sequencer_pkg::*;
#(
    parameter int RESP_DEPTH = 2,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    sram_port_sequencer_if.slave bus,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_done
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [ADDR_W:0]  init_ctr;
    logic [ADDR_W:0]  init_ctr_inc;
    logic             inflight;
    logic             inflight_next;
    sram_req_t        req;
    logic             req_ready;
    logic             accept;
    logic             read_ok;
    logic             pop;
    logic             resp_valid;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    assign req = '{write: bus.req_write, addr: bus.req_addr,
                   wmask: bus.req_wmask, wdata: bus.req_wdata};

    assign init_ctr_inc   = init_ctr + 1'b1;
    assign resp_valid     = ~empty;
    assign pop            = resp_valid & bus.resp_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.req_ready  = req_ready;
    assign init_done      = (state == RUN);

    // Read credit: buffered entries plus the read whose data arrives this
    // edge, less the entry leaving this edge, must leave a free slot.
    always_comb begin
        read_ok = 1'b0;
        if (inflight) begin
            read_ok = (({1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop))
                       < (CNT_W+1)'(RESP_DEPTH));
        end else begin
            read_ok = ~full | pop;
        end
    end

    // Next state and macro drive.
    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        accept        = 1'b0;
        inflight_next = 1'b0;
        sram_en       = 1'b0;
        sram_wmode    = 1'b0;
        sram_addr     = req.addr;
        sram_wmask    = '0;
        sram_wdata    = req.wdata;
        case (state)
            INIT: begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_addr  = init_ctr[ADDR_W-1:0];
                sram_wmask = '1;
                sram_wdata = '0;
                // Carry into the top bit means this cycle writes the last row.
                if (init_ctr_inc[ADDR_W]) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                req_ready     = req.write | read_ok;
                accept        = bus.req_valid & req_ready;
                sram_en       = accept;
                sram_wmode    = accept & req.write;
                sram_wmask    = accept ? req.wmask : '0;
                inflight_next = accept & ~req.write;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // State register, zero-fill counter and read-in-flight flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT_EN ? INIT : RUN;
            init_ctr <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= inflight_next;
            if (state == INIT) begin
                init_ctr <= init_ctr_inc;
            end
        end
    end

    // Macro read data is captured the cycle after the read was issued.
    sram_resp_fifo #(
        .DATA_W    (DATA_W),
        .RESP_DEPTH(RESP_DEPTH)
    ) u_resp_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (inflight),
        .push_data(sram_rdata),
        .pop      (pop),
        .pop_data (bus.resp_rdata),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

endmodule
